// File: rtl/gsim_pkg.sv
// Shared types, widths and band coefficients for the banded-solver host checker.
// The helpers sign-extend operands into the residual width and take magnitudes.
package gsim_pkg;
  localparam int N   = 16;
  localparam int B_W = 16;
  localparam int X_W = 32;
  localparam int R_W = 40;

  localparam logic signed [R_W-1:0] C0 = 40'sd20;
  localparam logic signed [R_W-1:0] C1 = -40'sd13;
  localparam logic signed [R_W-1:0] C2 = 40'sd6;
  localparam logic signed [R_W-1:0] C3 = -40'sd1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEND_B  = 3'd1,
    ST_WAIT_X  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  function automatic logic signed [R_W-1:0] sext_b(input logic [B_W-1:0] v);
    return {{(R_W-B_W){v[B_W-1]}}, v};
  endfunction

  function automatic logic signed [R_W-1:0] sext_x(input logic [X_W-1:0] v);
    return {{(R_W-X_W){v[X_W-1]}}, v};
  endfunction

  function automatic logic [R_W-1:0] abs_r(input logic signed [R_W-1:0] v);
    return v[R_W-1] ? (~v + 40'd1) : v;
  endfunction
endpackage

// File: rtl/gsim_row_residual.sv
// One row of the banded residual: r = (b <<< 16) - A*x, with A = band(-1,6,-13,20,-13,6,-1).
// taps[0] is x[i-3] ... taps[6] is x[i+3]; out-of-range taps arrive already zeroed.
module gsim_row_residual
  import gsim_pkg::*;
(
  input  logic [B_W-1:0]          b,
  input  logic [6:0][X_W-1:0]     taps,
  output logic signed [R_W-1:0]   r
);

  logic signed [R_W-1:0] b_sh_s;
  logic signed [R_W-1:0] band_s;

  // Scale b to Q16.16 and subtract the band product, all in 40-bit two's complement.
  always_comb begin
    b_sh_s = sext_b(b) <<< 5'd16;
    band_s = C0 * sext_x(taps[3])
           + C1 * (sext_x(taps[2]) + sext_x(taps[4]))
           + C2 * (sext_x(taps[1]) + sext_x(taps[5]))
           + C3 * (sext_x(taps[0]) + sext_x(taps[6]));
    r      = b_sh_s - band_s;
  end

endmodule

// File: rtl/gsim_host.sv
// Host-side harness for a 16-row banded solver: streams b out, collects x back,
// then recomputes every row residual and reports pass/timeout/max_err.
module gsim_host
  import gsim_pkg::*;
#(
  parameter logic [31:0] TOL     = 32'd4096,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            b_wr_en,
  input  logic [3:0]      b_wr_addr,
  input  logic [B_W-1:0]  b_wr_data,
  input  logic            start,
  output logic            in_en,
  output logic [B_W-1:0]  b_in,
  input  logic            out_valid,
  input  logic [X_W-1:0]  x_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [R_W-1:0]  max_err
);

  state_t                state_r, state_s;
  logic [B_W-1:0]        b_mem_r [N];
  logic [X_W-1:0]        x_mem_r [N];
  logic [4:0]            idx_r;
  logic [15:0]           wait_cnt_r;
  logic                  in_en_r, busy_r, done_r, pass_r, timeout_r;
  logic [B_W-1:0]        b_in_r;
  logic [R_W-1:0]        max_err_r;
  logic                  wait_expired_s;
  logic [6:0][X_W-1:0]   taps_s;
  logic signed [R_W-1:0] resid_s;
  logic [R_W-1:0]        abs_s, max_next_s;

  // wait_cnt_r holds cycles elapsed since the last in_en beat.
  assign wait_expired_s = ({1'b0, wait_cnt_r} + 17'd1) >= {1'b0, TIMEOUT};

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:    if (start) state_s = ST_SEND_B; else state_s = ST_IDLE;
      ST_SEND_B:  if (idx_r == 5'd16) state_s = ST_WAIT_X; else state_s = ST_SEND_B;
      ST_WAIT_X: begin
        if (out_valid)           state_s = ST_CAPTURE;
        else if (wait_expired_s) state_s = ST_DONE;
        else                     state_s = ST_WAIT_X;
      end
      ST_CAPTURE: if (out_valid && (idx_r == 5'd15)) state_s = ST_CHECK; else state_s = ST_CAPTURE;
      ST_CHECK:   if (idx_r == 5'd15) state_s = ST_CHECK_LAST(); else state_s = ST_CHECK;
      ST_DONE:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  function automatic state_t ST_CHECK_LAST();
    return ST_DONE;
  endfunction

  // Gather the seven band taps around row idx_r, zeroing those off either end.
  always_comb begin
    taps_s = '0;
    for (int k = 0; k < 7; k++) begin
      int j;
      j = int'(idx_r[3:0]) + k - 3;
      if ((j >= 0) && (j < N)) taps_s[k] = x_mem_r[j[3:0]];
      else                     taps_s[k] = '0;
    end
  end

  gsim_row_residual u_row (
    .b    (b_mem_r[idx_r[3:0]]),
    .taps (taps_s),
    .r    (resid_s)
  );

  // Running maximum of |r_i|.
  always_comb begin
    abs_s = abs_r(resid_s);
    if (abs_s > max_err_r) max_next_s = abs_s;
    else                   max_next_s = max_err_r;
  end

  // State, storage and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= 5'd0;
      wait_cnt_r <= 16'd0;
      in_en_r    <= 1'b0;
      b_in_r     <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      timeout_r  <= 1'b0;
      max_err_r  <= '0;
      for (int i = 0; i < N; i++) begin
        b_mem_r[i] <= '0;
        x_mem_r[i] <= '0;
      end
    end else begin
      state_r <= state_s;
      done_r  <= (state_s == ST_DONE);
      busy_r  <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (b_wr_en) b_mem_r[b_wr_addr] <= b_wr_data;
          if (start) begin
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
            max_err_r <= '0;
            in_en_r   <= 1'b1;
            b_in_r    <= b_mem_r[0];
            idx_r     <= 5'd1;
          end
        end
        ST_SEND_B: begin
          if (idx_r == 5'd16) begin
            in_en_r    <= 1'b0;
            b_in_r     <= '0;
            wait_cnt_r <= 16'd1;
            idx_r      <= 5'd0;
          end else begin
            b_in_r <= b_mem_r[idx_r[3:0]];
            idx_r  <= idx_r + 5'd1;
          end
        end
        ST_WAIT_X: begin
          if (out_valid) begin
            x_mem_r[0] <= x_out;
            idx_r      <= 5'd1;
          end else if (wait_expired_s) begin
            timeout_r <= 1'b1;
            pass_r    <= 1'b0;
            max_err_r <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
          end
        end
        ST_CAPTURE: begin
          if (out_valid) begin
            x_mem_r[idx_r[3:0]] <= x_out;
            if (idx_r == 5'd15) idx_r <= 5'd0;
            else                idx_r <= idx_r + 5'd1;
          end
        end
        ST_CHECK: begin
          max_err_r <= max_next_s;
          idx_r     <= idx_r + 5'd1;
          if (idx_r == 5'd15) pass_r <= (max_next_s <= {8'd0, TOL});
        end
        ST_DONE: begin
          idx_r <= 5'd0;
        end
        default: begin
          idx_r <= 5'd0;
        end
      endcase
    end
  end

  assign in_en   = in_en_r;
  assign b_in    = b_in_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign pass    = pass_r;
  assign timeout = timeout_r;
  assign max_err = max_err_r;

endmodule

// File: tb/tb_gsim_host.sv
// Directed bench for gsim_host: a table of b/x runs checked against hand-computed
// residual maxima on two instances (default TOL/TIMEOUT and TOL=10, TIMEOUT=100).
module tb_gsim_host;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, b_wr_en, start, out_valid;
  logic [3:0]  b_wr_addr;
  logic [15:0] b_wr_data;
  logic [31:0] x_out;
  logic        in_en_a, busy_a, done_a, pass_a, timeout_a;
  logic [15:0] b_in_a;
  logic [39:0] max_err_a;
  logic        in_en_b, busy_b, done_b, pass_b, timeout_b;
  logic [15:0] b_in_b;
  logic [39:0] max_err_b;

  gsim_host dut_a (
    .clk(clk), .reset(reset), .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .start(start), .in_en(in_en_a), .b_in(b_in_a), .out_valid(out_valid), .x_out(x_out),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a), .max_err(max_err_a)
  );

  gsim_host #(.TOL(32'd10), .TIMEOUT(16'd100)) dut_b (
    .clk(clk), .reset(reset), .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .start(start), .in_en(in_en_b), .b_in(b_in_b), .out_valid(out_valid), .x_out(x_out),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b), .max_err(max_err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0][15:0] b;
    logic [15:0][31:0] x;
    logic              gap;
    logic              extra;
    logic [39:0]       exp_max;
    logic              exp_pass_a;
    logic              exp_pass_b;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic write_b(input logic [15:0][15:0] b);
    for (int i = 0; i < 16; i++) begin
      b_wr_en = 1'b1; b_wr_addr = i[3:0]; b_wr_data = b[i];
      @(negedge clk);
    end
    b_wr_en = 1'b0;
  endtask

  // Starts a run, checks the b stream, plays back x as a stub solver, checks the result.
  task automatic run_vec(input vec_t v, input bit do_write, input string tag);
    int beats, last_x, found;
    if (do_write) write_b(v.b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_first_beat"}, {in_en_a, busy_a}, 2'b11);
    beats = 0;
    for (int t = 0; t < 40; t++) begin
      if (!in_en_a) break;
      check({tag, "_b_in"}, b_in_a, v.b[beats]);
      beats++;
      @(negedge clk);
    end
    check({tag, "_beats"}, beats, 16);
    check({tag, "_b_in_idle"}, b_in_a, 16'd0);
    if (v.extra) begin
      start = 1'b1; b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 16'h7FFF;
    end
    @(negedge clk);
    start = 1'b0; b_wr_en = 1'b0;
    @(negedge clk);
    last_x = 0;
    for (int k = 0; k < 16; k++) begin
      out_valid = 1'b1; x_out = v.x[k]; last_x = cyc;
      @(negedge clk);
      if (v.gap && (k == 5)) begin
        out_valid = 1'b0; x_out = 32'h12345678;
        @(negedge clk);
      end
    end
    if (v.extra) begin
      out_valid = 1'b1; x_out = 32'h7FFFFFFF;
      @(negedge clk);
    end
    out_valid = 1'b0; x_out = 32'd0;
    found = 0;
    for (int t = 0; t < 60; t++) begin
      if (done_a) begin found = 1; break; end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, found, 1);
    check({tag, "_done_latency"}, cyc - last_x, 17);
    check({tag, "_busy_at_done"}, busy_a, 1'b0);
    check({tag, "_done_b"}, done_b, 1'b1);
    check({tag, "_max_err_a"}, max_err_a, v.exp_max);
    check({tag, "_max_err_b"}, max_err_b, v.exp_max);
    check({tag, "_pass_a"}, pass_a, v.exp_pass_a);
    check({tag, "_pass_b"}, pass_b, v.exp_pass_b);
    check({tag, "_timeout"}, {timeout_a, timeout_b}, 2'b00);
    @(negedge clk);
    check({tag, "_done_pulse"}, {done_a, busy_a}, 2'b00);
    check({tag, "_pass_held"}, pass_a, v.exp_pass_a);
  endtask

  initial begin
    int beats, last_b, found, dones;
    for (int i = 0; i < 9; i++) begin
      vecs[i].b = '0; vecs[i].x = '0; vecs[i].gap = 1'b0; vecs[i].extra = 1'b0;
      vecs[i].exp_max = 40'd0; vecs[i].exp_pass_a = 1'b1; vecs[i].exp_pass_b = 1'b1;
    end
    for (int i = 1; i <= 3; i++) begin
      vecs[i].b[0] = 16'd20; vecs[i].b[1] = 16'hFFF3; vecs[i].b[2] = 16'd6; vecs[i].b[3] = 16'hFFFF;
      vecs[i].x[0] = 32'h00010000;
    end
    vecs[1].gap = 1'b1;
    vecs[2].x[0] = 32'h00010001; vecs[2].exp_max = 40'd20; vecs[2].exp_pass_b = 1'b0;
    vecs[3].extra = 1'b1;
    vecs[4].b[7] = 16'd1; vecs[4].exp_max = 40'd65536;
    vecs[4].exp_pass_a = 1'b0; vecs[4].exp_pass_b = 1'b0;
    vecs[5].x[15] = 32'h00000100; vecs[5].exp_max = 40'd5120;
    vecs[5].exp_pass_a = 1'b0; vecs[5].exp_pass_b = 1'b0;
    vecs[6].x[8] = 32'hFFFFFFF0; vecs[6].exp_max = 40'd320; vecs[6].exp_pass_b = 1'b0;
    vecs[7].x[4] = 32'h7FFFFFFF; vecs[7].exp_max = 40'd42949672940;
    vecs[7].exp_pass_a = 1'b0; vecs[7].exp_pass_b = 1'b0;
    vecs[8].b[0] = 16'hFFFF; vecs[8].exp_max = 40'd65536; vecs[8].gap = 1'b1;
    vecs[8].exp_pass_a = 1'b0; vecs[8].exp_pass_b = 1'b0;

    reset = 1'b1; b_wr_en = 1'b0; b_wr_addr = 4'd0; b_wr_data = 16'd0;
    start = 1'b0; out_valid = 1'b0; x_out = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {in_en_a, b_in_a, busy_a, done_a, pass_a, timeout_a, max_err_a}, '0);
    check("reset_outputs_b", {in_en_b, b_in_b, busy_b, done_b, pass_b, timeout_b, max_err_b}, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Solver never answers: dut_b gives up after 100 cycles, dut_a after 4096.
    write_b(vecs[1].b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0; last_b = 0;
    for (int t = 0; t < 40; t++) begin
      if (!in_en_a) break;
      beats++; last_b = cyc;
      @(negedge clk);
    end
    check("to_beats", beats, 16);
    found = 0;
    for (int t = 0; t < 200; t++) begin
      if (done_b) begin found = 1; break; end
      @(negedge clk);
    end
    check("to_b_done_seen", found, 1);
    check("to_b_latency", cyc - last_b, 100);
    check("to_b_flags", {timeout_b, pass_b, max_err_b}, {1'b1, 1'b0, 40'd0});
    check("to_a_still_busy", {busy_a, timeout_a}, 2'b10);
    found = 0;
    for (int t = 0; t < 5000; t++) begin
      if (done_a) begin found = 1; break; end
      @(negedge clk);
    end
    check("to_a_done_seen", found, 1);
    check("to_a_latency", cyc - last_b, 4096);
    check("to_a_flags", {timeout_a, pass_a, max_err_a}, {1'b1, 1'b0, 40'd0});
    @(negedge clk);
    check("to_b_held", timeout_b, 1'b1);

    // Reset on the 5th in_en beat aborts the run and clears b memory.
    write_b(vecs[4].b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    for (int t = 0; t < 40; t++) begin
      if (in_en_a) beats++;
      if (beats == 5) break;
      @(negedge clk);
    end
    check("rst_reached_beat5", beats, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_en_drop", {in_en_a, in_en_b, busy_a, b_in_a}, '0);
    dones = 0;
    for (int t = 0; t < 40; t++) begin
      if (done_a || done_b) dones++;
      @(negedge clk);
    end
    check("rst_no_done", dones, 0);
    run_vec(vecs[0], 1'b0, "fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gsim_host.md
GSIM_HOST -- requirements
Module: gsim_host

Interface
REQ-001 Parameter TOL, default 32'd4096, pass threshold on |residual| in Q16.16 LSBs (4096 = 1/16).
REQ-002 Parameter TIMEOUT, default 16'd4096, maximum cycles from last in_en beat to first out_valid beat.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 b_wr_en  input  1  write strobe for b memory.
REQ-006 b_wr_addr  input  4  b memory index 0..15.
REQ-007 b_wr_data  input  16  signed integer b value.
REQ-008 start  input  1  single-cycle request to run one solve-and-check.
REQ-009 in_en  output  1  b-stream valid, to solver.
REQ-010 b_in  output  16  b-stream data, to solver.
REQ-011 out_valid  input  1  x-stream valid, from solver.
REQ-012 x_out  input  32  signed Q16.16 x-stream data, from solver.
REQ-013 busy  output  1  high from accepted start until done.
REQ-014 done  output  1  one-cycle pulse at end of run.
REQ-015 pass  output  1  valid while done=1 and held until next start; 1 = all |r_i| <= TOL and no timeout.
REQ-016 timeout  output  1  held until next start; 1 = solver never answered.
REQ-017 max_err  output  40  max |r_i| over 16 rows, unsigned, held until next start.

Function
REQ-018 States: IDLE, SEND_B, WAIT_X, CAPTURE, CHECK, DONE.
REQ-019 IDLE: b_wr_en writes b_mem[b_wr_addr] on the clock edge; start=1 -> SEND_B, busy=1, clear pass/timeout/max_err.
REQ-020 b_wr_en outside IDLE and start outside IDLE shall be ignored.
REQ-021 SEND_B: in_en=1 for exactly 16 consecutive cycles, b_in=b_mem[0..15] in order, registered outputs; then in_en=0, b_in=0 -> WAIT_X.
REQ-022 WAIT_X: cycle counter from 0; first out_valid=1 -> CAPTURE, storing that beat as x[0]; counter reaching TIMEOUT -> DONE with timeout=1, pass=0, max_err=0.
REQ-023 CAPTURE: store x_out into x[1..15] on successive out_valid beats; beats with out_valid=0 are skipped without advancing the index; after x[15] -> CHECK.
REQ-024 Beats beyond the 16th (solver emits a trailing padding beat) and any out_valid outside WAIT_X/CAPTURE shall be ignored.
REQ-025 CHECK: one row per cycle, i=0..15, 16 cycles; r_i = (b_i <<< 16) - (20*x_i - 13*(x_{i-1}+x_{i+1}) + 6*(x_{i-2}+x_{i+2}) - (x_{i-3}+x_{i+3})), x_j=0 for j<0 or j>15.
REQ-026 Arithmetic: all operands sign-extended to 40 bits, no saturation; |r_i| as 40-bit unsigned; max_err updated as running maximum.
REQ-027 After row 15 -> DONE; pass = (max_err <= TOL).
REQ-028 DONE: done=1 for one cycle, busy=0 on the same cycle -> IDLE.
REQ-029 Latency: in_en first beat is the cycle after start is sampled; done is 16 cycles after the last x beat is captured, plus one cycle.

Reset
REQ-030 reset=1 at any state -> IDLE next edge; in_en, b_in, busy, done, pass, timeout, max_err all 0.
REQ-031 reset shall clear b_mem and x storage to 0.
REQ-032 Reset mid-SEND_B shall drop in_en on the next edge; the aborted run produces no done pulse.

Structure
REQ-033 Package gsim_pkg: N=16, band coefficients (20, -13, 6, -1), state enum, widths B_W=16, X_W=32, R_W=40.
REQ-034 Sub-module gsim_row_residual: combinational r_i from b_i and seven x taps, edge taps zeroed by the caller.

Verification
REQ-035 Real solver, all b=0 -> 16 in_en beats, pass=1, max_err=0, timeout=0.
REQ-036 Stub solver returns x0=0x00010000, others 0; b=[20,-13,6,-1,0...] -> pass=1, max_err=0.
REQ-037 Same b, stub x0=0x00010001 -> max_err=20, pass=1; with TOL=10 -> pass=0, max_err=20.
REQ-038 Stub never raises out_valid, TIMEOUT=100 -> done at 100 cycles after the last in_en beat, timeout=1, pass=0.
REQ-039 Stub emits 17 beats, the last 0x7FFFFFFF -> ignored, result identical to REQ-036; start pulsed while busy -> ignored.
REQ-040 reset asserted at the 5th in_en beat -> in_en=0 the next cycle, no done; a fresh start then runs normally.
